// File: rtl/picobello_irq_router_pkg.sv
// Shared constants, line encoding and hart-mapping helpers for the
// Cheshire-to-cluster interrupt router.
package picobello_irq_router_pkg;

    localparam int NumClusters   = 2;
    localparam int NrCores       = 9;
    localparam int NumExtHarts   = 18;
    localparam int IrqPipeStages = 2;
    localparam int IrqHoldCycles = 16;

    // Bit positions of the four lines of one core inside a pipe word
    localparam int LinesPerCore = 4;
    localparam int LnMeip       = 0;
    localparam int LnMtip       = 1;
    localparam int LnMsip       = 2;
    localparam int LnDbg        = 3;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } irq_state_e;

    function automatic int ext_hart_idx(
        input int hart_offset,
        input int nr_cores,
        input int c,
        input int k
    );
        return hart_offset + c * nr_cores + k;
    endfunction

    function automatic bit ext_hart_valid(
        input int hart_offset,
        input int nr_cores,
        input int num_ext_harts,
        input int c,
        input int k
    );
        return ext_hart_idx(hart_offset, nr_cores, c, k) < num_ext_harts;
    endfunction

endpackage

// File: rtl/picobello_irq_router_pipe.sv
// Fixed-depth retiming shift register with synchronous active-low clear.
// Zero stages degenerates to a wire.
module picobello_irq_pipe #(
    parameter int Width  = 4,
    parameter int Stages = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    if (Stages == 0) begin : g_wire
        logic w_unused_ctl;
        assign w_unused_ctl = i_clk ^ i_rst_n;
        assign o_q = i_d;
    end else begin : g_regs
        logic [Width-1:0] r_pipe [Stages];

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                r_pipe <= '{default: '0};
            end else begin
                r_pipe[0] <= i_d;
                for (int i = 1; i < Stages; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign o_q = r_pipe[Stages-1];
    end

endmodule

// File: rtl/picobello_irq_router.sv
// Routes Cheshire external IRQ/debug lines to every cluster core through a
// retiming pipe, gated off during a quiet period after reset.
module picobello_irq_router
    import picobello_irq_router_pkg::*;
#(
    parameter int NumClusters = picobello_irq_router_pkg::NumClusters,
    parameter int NrCores     = picobello_irq_router_pkg::NrCores,
    parameter int NumExtHarts = picobello_irq_router_pkg::NumExtHarts,
    parameter int NumIrqCtxts = 2,
    parameter int HartOffset  = 0,
    parameter int PipeStages  = IrqPipeStages,
    parameter int HoldCycles  = IrqHoldCycles
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumIrqCtxts*NumExtHarts-1:0]    xeip_ext_i,
    input  logic [NumExtHarts-1:0]                mtip_ext_i,
    input  logic [NumExtHarts-1:0]                msip_ext_i,
    input  logic [NumExtHarts-1:0]                debug_req_ext_i,
    output logic [NumClusters-1:0][NrCores-1:0]   meip_o,
    output logic [NumClusters-1:0][NrCores-1:0]   mtip_o,
    output logic [NumClusters-1:0][NrCores-1:0]   msip_o,
    output logic [NumClusters-1:0][NrCores-1:0]   debug_req_o,
    output logic                                  ready_o
);

    localparam int CntW = (HoldCycles > 0) ? $clog2(HoldCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(HoldCycles);
    localparam logic [CntW-1:0] CntLast = CntW'((HoldCycles > 0) ? HoldCycles - 1 : 0);
    localparam irq_state_e ResetState = (HoldCycles == 0) ? RUN : HOLD;
    localparam int PipeW = LinesPerCore * NrCores;

    irq_state_e      r_state;
    logic [CntW-1:0] r_cnt;
    logic            w_run;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ResetState;
            r_cnt   <= '0;
        end else begin
            if (r_cnt != CntMax) begin
                r_cnt <= r_cnt + CntW'(1);
            end
            unique case (r_state)
                HOLD: if (r_cnt == CntLast) r_state <= RUN;
                RUN:  r_state <= RUN;
            endcase
        end
    end

    assign w_run   = (r_state == RUN);
    assign ready_o = w_run;

    // S-context bits and harts outside the mapped window are never routed
    logic w_unused_src;
    assign w_unused_src = ^{xeip_ext_i, mtip_ext_i, msip_ext_i, debug_req_ext_i};

    for (genvar c = 0; c < NumClusters; c++) begin : g_cl
        logic [PipeW-1:0] w_d;
        logic [PipeW-1:0] w_q;

        for (genvar k = 0; k < NrCores; k++) begin : g_core
            localparam int H = ext_hart_idx(HartOffset, NrCores, c, k);

            if (ext_hart_valid(HartOffset, NrCores, NumExtHarts, c, k)) begin : g_map
                assign w_d[LinesPerCore*k +: LinesPerCore] = {
                    debug_req_ext_i[H],
                    msip_ext_i[H],
                    mtip_ext_i[H],
                    xeip_ext_i[H*NumIrqCtxts]
                };
                assign meip_o[c][k]      = w_q[LinesPerCore*k + LnMeip] & w_run;
                assign mtip_o[c][k]      = w_q[LinesPerCore*k + LnMtip] & w_run;
                assign msip_o[c][k]      = w_q[LinesPerCore*k + LnMsip] & w_run;
                assign debug_req_o[c][k] = w_q[LinesPerCore*k + LnDbg]  & w_run;
            end else begin : g_tie
                logic [LinesPerCore-1:0] w_unused_q;
                assign w_d[LinesPerCore*k +: LinesPerCore] = '0;
                assign w_unused_q        = w_q[LinesPerCore*k +: LinesPerCore];
                assign meip_o[c][k]      = 1'b0;
                assign mtip_o[c][k]      = 1'b0;
                assign msip_o[c][k]      = 1'b0;
                assign debug_req_o[c][k] = 1'b0;
            end
        end

        picobello_irq_pipe #(
            .Width  (PipeW),
            .Stages (PipeStages)
        ) u_pipe (
            .i_clk   (clk_i),
            .i_rst_n (rst_ni),
            .i_d     (w_d),
            .o_q     (w_q)
        );
    end

endmodule
